// File: rtl/hash_host_bridge_if.sv
// +-----------------------------------------------------------------+
// | hash_host_bridge_if                                             |
// | Host beat bus, control/status and hash core word/digest signals |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface hash_host_bridge_if #(
    parameter int BUS_W    = 8,
    parameter int WORD_W   = 32,
    parameter int DIGEST_W = 256
) ();
    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic                err;

    logic                host_rdy;
    logic [BUS_W-1:0]    host_din;
    logic                host_rq;
    logic [BUS_W-1:0]    host_dout;

    logic                core_start;
    logic                core_rdy;
    logic [WORD_W-1:0]   core_data;
    logic                core_rq;
    logic                core_done;
    logic [DIGEST_W-1:0] core_digest;

    // Bridge side
    modport master (
        input  start, abort, host_rdy, host_din, core_rq, core_done, core_digest,
        output busy, done, err, host_rq, host_dout, core_start, core_rdy, core_data
    );

    // Host / core side
    modport slave (
        output start, abort, host_rdy, host_din, core_rq, core_done, core_digest,
        input  busy, done, err, host_rq, host_dout, core_start, core_rdy, core_data
    );
endinterface

`default_nettype wire

// File: rtl/hash_host_bridge.sv
// +-----------------------------------------------------------------+
// | hash_host_bridge                                                |
// | Assembles host beats into core words, streams digest back out.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module hash_host_bridge #(
    parameter int BUS_W     = 8,
    parameter int WORD_W    = 32,
    parameter int DIGEST_W  = 256,
    parameter int OUT_BEATS = 32,
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    hash_host_bridge_if.master bus
);

    localparam int WORD_BEATS = WORD_W / BUS_W;
    localparam int DIG_BEATS  = DIGEST_W / BUS_W;
    localparam int MAX_BEATS  = (WORD_BEATS > OUT_BEATS) ? WORD_BEATS : OUT_BEATS;
    localparam int CNT_W      = $clog2(MAX_BEATS) + 1;
    localparam int TO_W       = $clog2(TIMEOUT + 1) + 1;

    localparam logic [CNT_W-1:0] c_WORD_LAST = CNT_W'(WORD_BEATS - 1);
    localparam logic [CNT_W-1:0] c_OUT_BEATS = CNT_W'(OUT_BEATS);
    localparam logic [TO_W-1:0]  c_TO_LAST   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WAIT  = 3'd1;
    localparam logic [2:0] c_ST_FETCH = 3'd2;
    localparam logic [2:0] c_ST_PUSH  = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;

    logic                r_host_rq;
    logic [BUS_W-1:0]    r_host_dout;
    logic                r_done;
    logic                r_err;
    logic                r_core_start;
    logic                r_core_rdy;
    logic [WORD_W-1:0]   r_core_data;
    logic [WORD_W-1:0]   r_word;
    logic [DIGEST_W-1:0] r_digest;
    logic [CNT_W-1:0]    r_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_core_rq_d;

    logic                w_busy;
    logic                w_rq_edge;
    logic                w_handshake;
    logic                w_idle_bus;
    logic                w_drain_end;
    logic                w_timeout;
    logic                w_fire_start;
    logic                w_rq_raise;
    logic                w_capture;
    logic                w_push;
    logic                w_load_digest;
    logic                w_start_fetch;
    logic                w_drain_exit;
    logic [WORD_W-1:0]   w_word_nxt;
    logic [BUS_W-1:0]    w_beat_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_timeout) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (bus.start) w_state_nxt = c_ST_WAIT;
                // A finished core takes priority over a coincident word request.
                c_ST_WAIT: begin
                    if (bus.core_done)   w_state_nxt = c_ST_DRAIN;
                    else if (w_rq_edge)  w_state_nxt = c_ST_FETCH;
                end
                c_ST_FETCH: if (w_push) w_state_nxt = c_ST_PUSH;
                c_ST_PUSH:  w_state_nxt = c_ST_WAIT;
                c_ST_DRAIN: if (w_drain_exit) w_state_nxt = c_ST_IDLE;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy        = (r_state != c_ST_IDLE);
        w_rq_edge     = bus.core_rq & ~r_core_rq_d;
        w_handshake   = r_host_rq & bus.host_rdy;
        w_idle_bus    = ~r_host_rq & ~bus.host_rdy;
        w_drain_end   = (r_cnt == c_OUT_BEATS);
        w_timeout     = (TIMEOUT != 0) && r_host_rq && !bus.host_rdy && (r_to_cnt == c_TO_LAST);
        w_fire_start  = !bus.abort && (r_state == c_ST_IDLE) && bus.start;
        // New beat only once the host has released rdy from the previous one.
        w_rq_raise    = !bus.abort && w_idle_bus &&
                        ((r_state == c_ST_FETCH) || ((r_state == c_ST_DRAIN) && !w_drain_end));
        w_capture     = !bus.abort && (r_state == c_ST_FETCH) && w_handshake;
        w_push        = w_capture && (r_cnt == c_WORD_LAST);
        w_load_digest = !bus.abort && (r_state == c_ST_WAIT) && bus.core_done;
        w_start_fetch = !bus.abort && (r_state == c_ST_WAIT) && !bus.core_done && w_rq_edge;
        w_drain_exit  = !bus.abort && (r_state == c_ST_DRAIN) && w_idle_bus && w_drain_end;

        w_word_nxt = r_word;
        for (int s = 0; s < WORD_BEATS; s++) begin
            if (int'(r_cnt) == s) begin
                if (MSB_FIRST != 0) w_word_nxt[WORD_W-1-s*BUS_W -: BUS_W] = bus.host_din;
                else                w_word_nxt[s*BUS_W +: BUS_W]          = bus.host_din;
            end
        end

        w_beat_sel = '0;
        for (int s = 0; s < DIG_BEATS; s++) begin
            if (int'(r_cnt) == s) w_beat_sel = r_digest[DIGEST_W-1-s*BUS_W -: BUS_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_host_rq    <= 1'b0;
            r_host_dout  <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_start <= 1'b0;
            r_core_rdy   <= 1'b0;
            r_core_data  <= '0;
            r_word       <= '0;
            r_digest     <= '0;
            r_cnt        <= '0;
            r_to_cnt     <= '0;
            r_core_rq_d  <= 1'b0;
        end else begin
            r_core_rq_d  <= bus.core_rq;
            r_core_start <= w_fire_start;
            r_core_rdy   <= w_push;
            if (bus.abort) begin
                r_host_rq <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                if (w_fire_start) r_err <= 1'b0;
                if (w_timeout) begin
                    r_err     <= 1'b1;
                    r_host_rq <= 1'b0;
                    r_done    <= 1'b0;
                end else if (w_rq_raise) begin
                    r_host_rq <= 1'b1;
                    r_to_cnt  <= '0;
                    if (r_state == c_ST_DRAIN) r_host_dout <= w_beat_sel;
                end else if (w_handshake) begin
                    r_host_rq <= 1'b0;
                    r_cnt     <= r_cnt + 1'b1;
                end else if (r_host_rq && (r_to_cnt != '1)) begin
                    r_to_cnt  <= r_to_cnt + 1'b1;
                end
                if (w_capture) r_word      <= w_word_nxt;
                if (w_push)    r_core_data <= w_word_nxt;
                if (w_load_digest) begin
                    r_digest <= bus.core_digest;
                    r_cnt    <= '0;
                    r_done   <= 1'b1;
                end
                if (w_start_fetch) r_cnt  <= '0;
                if (w_drain_exit)  r_done <= 1'b0;
            end
        end
    end

    assign bus.host_rq    = r_host_rq;
    assign bus.host_dout  = r_host_dout;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.core_start = r_core_start;
    assign bus.core_rdy   = r_core_rdy;
    assign bus.core_data  = r_core_data;

endmodule

`default_nettype wire

// File: tb/tb_hash_host_bridge.sv
// +-----------------------------------------------------------------+
// | tb_hash_host_bridge                                             |
// | Directed bench: MS-first and LS-first bridges driven in lockstep|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_hash_host_bridge;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [255:0] dig;
    logic [7:0]   beats [4];

    always #5 clk = ~clk;

    hash_host_bridge_if #(.BUS_W(8), .WORD_W(32), .DIGEST_W(256)) if_m ();
    hash_host_bridge_if #(.BUS_W(8), .WORD_W(32), .DIGEST_W(256)) if_l ();

    hash_host_bridge #(.BUS_W(8), .WORD_W(32), .DIGEST_W(256), .OUT_BEATS(4),
                       .MSB_FIRST(1), .TIMEOUT(15))
        u_dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));

    hash_host_bridge #(.BUS_W(8), .WORD_W(32), .DIGEST_W(256), .OUT_BEATS(4),
                       .MSB_FIRST(0), .TIMEOUT(15))
        u_dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));

    // Second bridge sees exactly the same stimulus.
    assign if_l.start       = if_m.start;
    assign if_l.abort       = if_m.abort;
    assign if_l.host_rdy    = if_m.host_rdy;
    assign if_l.host_din    = if_m.host_din;
    assign if_l.core_rq     = if_m.core_rq;
    assign if_l.core_done   = if_m.core_done;
    assign if_l.core_digest = if_m.core_digest;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rq(input string tag);
        int n;
        n = 0;
        while (if_m.host_rq !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        chk(tag, 256'(if_m.host_rq), 256'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_host_rq"},    256'(if_m.host_rq),    256'd0);
        chk({tag, "_host_dout"},  256'(if_m.host_dout),  256'd0);
        chk({tag, "_busy"},       256'(if_m.busy),       256'd0);
        chk({tag, "_done"},       256'(if_m.done),       256'd0);
        chk({tag, "_err"},        256'(if_m.err),        256'd0);
        chk({tag, "_core_start"}, 256'(if_m.core_start), 256'd0);
        chk({tag, "_core_rdy"},   256'(if_m.core_rdy),   256'd0);
        chk({tag, "_core_data"},  256'(if_m.core_data),  256'd0);
        chk({tag, "_core_data_l"},256'(if_l.core_data),  256'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if_m.start = 1'b0; if_m.abort = 1'b0; if_m.host_rdy = 1'b0; if_m.host_din = 8'h00;
        if_m.core_rq = 1'b0; if_m.core_done = 1'b0; if_m.core_digest = '0;
        beats[0] = 8'h12; beats[1] = 8'h34; beats[2] = 8'h56; beats[3] = 8'h78;
        for (int k = 0; k < 32; k++) dig[255-8*k -: 8] = 8'(k);
        rst_n = 1'b0;
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // core_rq already high on entering WAIT: no edge, so no fetch.
        if_m.core_rq = 1'b1;
        tick(2);
        if_m.start = 1'b1;
        tick(1);
        chk("start_pulse", 256'(if_m.core_start), 256'd1);
        chk("start_busy",  256'(if_m.busy),       256'd1);
        if_m.start = 1'b0;
        tick(1);
        chk("start_pulse_end", 256'(if_m.core_start), 256'd0);
        tick(2);
        chk("no_edge_no_rq", 256'(if_m.host_rq), 256'd0);
        if_m.core_rq = 1'b0;
        tick(1);
        if_m.core_rq = 1'b1;
        tick(1);

        // Word fetch; rdy held high after the first beat.
        wait_rq("f0_rq");
        if_m.host_din = beats[0];
        if_m.host_rdy = 1'b1;
        tick(1);
        chk("f0_rq_drop", 256'(if_m.host_rq), 256'd0);
        tick(3);
        chk("hold_rdy_no_rq", 256'(if_m.host_rq), 256'd0);
        if_m.host_rdy = 1'b0;
        for (int i = 1; i < 4; i++) begin
            wait_rq("fn_rq");
            if_m.host_din = beats[i];
            if_m.host_rdy = 1'b1;
            tick(1);
            if_m.host_rdy = 1'b0;
        end
        chk("push_rdy",    256'(if_m.core_rdy),  256'd1);
        chk("word_msb",    256'(if_m.core_data), 256'h12345678);
        chk("word_lsb",    256'(if_l.core_data), 256'h78563412);
        tick(1);
        chk("push_rdy_end", 256'(if_m.core_rdy), 256'd0);
        chk("push_to_wait", 256'(if_m.busy),     256'd1);
        tick(3);
        chk("word_stable", 256'(if_m.core_data), 256'h12345678);

        // Digest drain, 4 beats, MS byte first.
        if_m.core_digest = dig;
        if_m.core_done   = 1'b1;
        tick(1);
        chk("drain_done", 256'(if_m.done), 256'd1);
        if_m.core_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_rq("d_rq");
            chk("d_dout", 256'(if_m.host_dout), 256'(i));
            if_m.host_rdy = 1'b1;
            tick(1);
            if_m.host_rdy = 1'b0;
        end
        tick(1);
        chk("drain_end_done", 256'(if_m.done),    256'd0);
        chk("drain_end_busy", 256'(if_m.busy),    256'd0);
        chk("drain_end_rq",   256'(if_m.host_rq), 256'd0);

        // Host never answers: 15 cycles of rq then error.
        if_m.start = 1'b1;
        tick(1);
        if_m.start   = 1'b0;
        if_m.core_rq = 1'b0;
        tick(1);
        if_m.core_rq = 1'b1;
        tick(1);
        wait_rq("to_rq");
        tick(14);
        chk("to_rq_still", 256'(if_m.host_rq), 256'd1);
        chk("to_err_early", 256'(if_m.err),    256'd0);
        tick(1);
        chk("to_err",  256'(if_m.err),     256'd1);
        chk("to_busy", 256'(if_m.busy),    256'd0);
        chk("to_rq",   256'(if_m.host_rq), 256'd0);

        // Abort beats start; err is left alone.
        if_m.start = 1'b1;
        if_m.abort = 1'b1;
        tick(1);
        chk("abort_start_busy", 256'(if_m.busy),       256'd0);
        chk("abort_start_cs",   256'(if_m.core_start), 256'd0);
        chk("abort_keeps_err",  256'(if_m.err),        256'd1);
        if_m.abort = 1'b0;
        tick(1);
        chk("restart_cs",  256'(if_m.core_start), 256'd1);
        chk("restart_err", 256'(if_m.err),        256'd0);
        if_m.start = 1'b0;

        // Abort on the third drain beat.
        if_m.core_done = 1'b1;
        tick(1);
        if_m.core_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_rq("ab_rq");
            if_m.host_rdy = 1'b1;
            tick(1);
            if_m.host_rdy = 1'b0;
        end
        wait_rq("ab2_rq");
        chk("ab2_dout", 256'(if_m.host_dout), 256'd2);
        if_m.abort = 1'b1;
        tick(1);
        chk("abort_rq",   256'(if_m.host_rq), 256'd0);
        chk("abort_done", 256'(if_m.done),    256'd0);
        chk("abort_busy", 256'(if_m.busy),    256'd0);
        if_m.abort = 1'b0;

        // Reset in the middle of a word fetch.
        if_m.start = 1'b1;
        tick(1);
        if_m.start   = 1'b0;
        if_m.core_rq = 1'b0;
        tick(1);
        if_m.core_rq = 1'b1;
        tick(1);
        wait_rq("rs_rq0");
        if_m.host_din = 8'hAB;
        if_m.host_rdy = 1'b1;
        tick(1);
        if_m.host_rdy = 1'b0;
        wait_rq("rs_rq1");
        rst_n = 1'b0;
        tick(1);
        chk_all_zero("midreset");
        rst_n = 1'b1;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
